// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the memory-mapped data memory:
//   region_e  - address region decoded from ADDR[13:12]
//   size_e    - access size (byte / half / word / dword)
//   LED_*     - LED block register offsets (ADDR[4:3])
//   SW_*      - switch block register offsets (ADDR[4:3])
//   state_e   - request FSM state
//   size_mask - low address bits that must be zero for an aligned access
// -----------------------------------------------------------------------------
package dmem_pkg;

   typedef enum logic [1:0] {
      REG_RAM  = 2'd0,
      REG_LED  = 2'd1,
      REG_SW   = 2'd2,
      REG_NONE = 2'd3
   } region_e;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } size_e;

   localparam logic [1:0] LED_WR  = 2'd0;
   localparam logic [1:0] LED_SET = 2'd1;
   localparam logic [1:0] LED_CLR = 2'd2;
   localparam logic [1:0] LED_TGL = 2'd3;

   localparam logic [1:0] SW_VAL  = 2'd0;
   localparam logic [1:0] SW_CHG  = 2'd1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   function automatic logic [2:0] size_mask(input size_e sz);
      case (sz)
         SZ_B:    return 3'b000;
         SZ_H:    return 3'b001;
         SZ_W:    return 3'b011;
         default: return 3'b111;
      endcase
   endfunction

endpackage

// File: rtl/data_memory_mmio_sw_sync.sv
// -----------------------------------------------------------------------------
// sw_sync
// Synchronises asynchronous switch inputs and keeps sticky per-bit change flags.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   sw_i       - raw asynchronous switch inputs
//   rd_clr_i   - clears the change flags (read-clear from the bus)
//   sw_o       - synchronised switch value
//   chg_o      - sticky change flags
// -----------------------------------------------------------------------------
module sw_sync #(
   parameter int N_SW        = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_SW-1:0] sw_i,
   input  logic            rd_clr_i,
   output logic [N_SW-1:0] sw_o,
   output logic [N_SW-1:0] chg_o
);

   logic [N_SW-1:0] sync_q [SYNC_STAGES];
   logic [N_SW-1:0] prev_q;
   logic [N_SW-1:0] chg_q;
   logic [N_SW-1:0] chg_d;

   // A change arriving in the same cycle as the read-clear must survive it,
   // so the fresh difference is OR-ed in after the clear.
   assign chg_d = (chg_q & ~{N_SW{rd_clr_i}}) | (sync_q[SYNC_STAGES-1] ^ prev_q);

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours, which is what makes the chain shift.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
         prev_q <= '0;
         chg_q  <= '0;
      end else begin
         sync_q[0] <= sw_i;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         prev_q <= sync_q[SYNC_STAGES-1];
         chg_q  <= chg_d;
      end
   end

   assign sw_o  = sync_q[SYNC_STAGES-1];
   assign chg_o = chg_q;

endmodule

// File: rtl/data_memory_mmio.sv
// -----------------------------------------------------------------------------
// data_memory_mmio
// Big-endian byte-addressed RAM with memory-mapped LED and switch blocks.
// Region ADDR[13:12]: 00 RAM, 01 LED, 10 switches, 11 unmapped (error).
// Each accepted request is answered by a one-cycle rsp_valid pulse on the
// following cycle; the FSM accepts one request every two cycles.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   req_valid/ready   - request handshake
//   req_we            - 1 store, 0 load
//   req_size          - 0 byte, 1 half, 2 word, 3 dword
//   req_unsigned      - zero-extend loads when set
//   req_addr          - byte address
//   req_wdata         - right-justified store data
//   rsp_valid         - response strobe
//   rsp_rdata         - load result (0 on error or store)
//   rsp_err           - access fault
//   swi               - asynchronous switch inputs
//   led               - LED drive
// -----------------------------------------------------------------------------
module data_memory_mmio
   import dmem_pkg::*;
#(
   parameter int    XLEN        = 64,
   parameter int    DEPTH_BYTES = 64,
   parameter int    N_LED       = 8,
   parameter int    N_SW        = 8,
   parameter int    SYNC_STAGES = 2,
   parameter string INIT_FILE   = ""
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [1:0]       req_size,
   input  logic             req_unsigned,
   input  logic [XLEN-1:0]  req_addr,
   input  logic [XLEN-1:0]  req_wdata,
   output logic             rsp_valid,
   output logic [XLEN-1:0]  rsp_rdata,
   output logic             rsp_err,
   input  logic [N_SW-1:0]  swi,
   output logic [N_LED-1:0] led
);

   localparam int AW = $clog2(DEPTH_BYTES);

   // NOTE: RAM contents are deliberately not reset; a store completed before
   // reset must survive it, and a reset port would block RAM inference.
   logic [7:0] mem [DEPTH_BYTES];

   state_e          state_q;
   logic            ready_q;
   logic            rsp_valid_q;
   logic [XLEN-1:0] rsp_rdata_q;
   logic            rsp_err_q;
   logic [N_LED-1:0] led_q;
   logic [N_LED-1:0] led_d;
   logic [XLEN-1:0] rdata_d;
   logic            err_d;

   region_e         region;
   size_e           size;
   int              nbytes;
   logic [AW-1:0]   ram_idx;
   logic [XLEN-1:0] ram_raw;
   logic [7:0]      wbyte [8];
   logic [XLEN-1:0] wtmp;
   logic            fire;
   logic            ram_we;
   logic            sw_rd_clr;
   logic [N_SW-1:0] sw_val;
   logic [N_SW-1:0] sw_chg;
   logic            unused_addr_hi;

   assign unused_addr_hi = ^req_addr[XLEN-1:14];

   assign fire    = req_valid & ready_q;
   assign region  = region_e'(req_addr[13:12]);
   assign size    = size_e'(req_size);
   assign nbytes  = 1 << req_size;
   assign ram_idx = req_addr[AW-1:0];

   // Extension always starts from the top bit of the accessed unit.
   function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw,
                                              input size_e sz, input logic uns);
      case (sz)
         SZ_B:    return uns ? XLEN'(raw[7:0])  : XLEN'(signed'(raw[7:0]));
         SZ_H:    return uns ? XLEN'(raw[15:0]) : XLEN'(signed'(raw[15:0]));
         SZ_W:    return uns ? XLEN'(raw[31:0]) : XLEN'(signed'(raw[31:0]));
         default: return raw;
      endcase
   endfunction

   // NOTE: every variable driven in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      // Big-endian gather: the byte at the address shifts up to the MSB.
      ram_raw = '0;
      for (int i = 0; i < 8; i++) begin
         if (i < nbytes) ram_raw = {ram_raw[XLEN-9:0], mem[AW'(ram_idx + AW'(i))]};
      end

      // Left-justify the store unit so byte i is always the top byte.
      wtmp = req_wdata << ((8 - nbytes) * 8);
      for (int i = 0; i < 8; i++) begin
         wbyte[i] = wtmp[XLEN-1 -: 8];
         wtmp     = wtmp << 8;
      end
   end

   always_comb begin
      err_d = (req_addr[2:0] & size_mask(size)) != 3'b000;
      case (region)
         REG_RAM:  if (int'(req_addr[11:0]) + nbytes > DEPTH_BYTES) err_d = 1'b1;
         REG_LED,
         REG_SW:   if (size != SZ_D) err_d = 1'b1;
         default:  err_d = 1'b1;
      endcase

      rdata_d = '0;
      if (!err_d && !req_we) begin
         case (region)
            REG_RAM: rdata_d = extend(ram_raw, size, req_unsigned);
            REG_LED: rdata_d = XLEN'(led_q);
            REG_SW: begin
               if (req_addr[4:3] == SW_VAL)
                  rdata_d = req_unsigned ? XLEN'(sw_val) : XLEN'(signed'(sw_val));
               else if (req_addr[4:3] == SW_CHG)
                  rdata_d = XLEN'(sw_chg);
            end
            default: rdata_d = '0;
         endcase
      end

      led_d = led_q;
      if (fire && req_we && !err_d && region == REG_LED) begin
         case (req_addr[4:3])
            LED_WR:  led_d = req_wdata[N_LED-1:0];
            LED_SET: led_d = led_q |  req_wdata[N_LED-1:0];
            LED_CLR: led_d = led_q & ~req_wdata[N_LED-1:0];
            default: led_d = led_q ^  req_wdata[N_LED-1:0];
         endcase
      end
   end

   assign ram_we    = fire && req_we && !err_d && region == REG_RAM;
   assign sw_rd_clr = fire && !req_we && !err_d && region == REG_SW &&
                      req_addr[4:3] == SW_CHG;

   always_ff @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (ram_we && i < nbytes) mem[AW'(ram_idx + AW'(i))] <= wbyte[i];
      end
   end

   // Results are captured at the accept edge; rsp_valid follows one edge
   // later, so a reset during BUSY suppresses the response entirely.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         led_q       <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               rsp_valid_q <= 1'b0;
               ready_q     <= 1'b1;
               if (fire) begin
                  state_q     <= ST_BUSY;
                  ready_q     <= 1'b0;
                  rsp_rdata_q <= rdata_d;
                  rsp_err_q   <= err_d;
                  led_q       <= led_d;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               ready_q     <= 1'b1;
               rsp_valid_q <= 1'b1;
            end
         endcase
      end
   end

   sw_sync #(
      .N_SW        (N_SW),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sw_sync (
      .clk      (clk),
      .rst      (rst),
      .sw_i     (swi),
      .rd_clr_i (sw_rd_clr),
      .sw_o     (sw_val),
      .chg_o    (sw_chg)
   );

   assign req_ready = ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign led       = led_q;

endmodule

// File: tb/tb_data_memory_mmio.sv
// -----------------------------------------------------------------------------
// tb_data_memory_mmio
// Directed test of data_memory_mmio with hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_data_memory_mmio;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        rsp_valid;
   logic [63:0] rsp_rdata;
   logic        rsp_err;
   logic [7:0]  swi;
   logic [7:0]  led;

   int total = 0;
   int bad   = 0;

   data_memory_mmio #(
      .XLEN(64), .DEPTH_BYTES(64), .N_LED(8), .N_SW(8), .SYNC_STAGES(2), .INIT_FILE("")
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .swi          (swi),
      .led          (led)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One complete access: drive, wait for accept, verify the BUSY cycle and the
   // response one cycle after accept.
   task automatic access(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         output logic [63:0] rdata, output logic err);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("accept_ready", req_ready, 1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("busy_no_valid", rsp_valid, 0);
      check("busy_not_ready", req_ready, 0);
      @(posedge clk); #1;
      check("rsp_valid_latency", rsp_valid, 1);
      rdata = rsp_rdata;
      err   = rsp_err;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] rd;
      logic        er;

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; swi = 8'h00;
      #2;
      check("rst_led", led, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_rdata", rsp_rdata, 0);
      check("rst_err", rsp_err, 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("ready_after_rst", req_ready, 1);

      // RAM: big-endian sized loads
      access(1, 2'd3, 0, 64'h0, 64'h0123456789ABCDEF, rd, er);
      check("st_d0_err", er, 0);
      access(0, 2'd0, 0, 64'h0, 64'h0, rd, er);
      check("ld_b0_s", rd, 64'h01);
      access(0, 2'd0, 0, 64'h7, 64'h0, rd, er);
      check("ld_b7_s", rd, 64'hFFFFFFFFFFFFFFEF);
      access(0, 2'd0, 1, 64'h7, 64'h0, rd, er);
      check("ld_b7_u", rd, 64'hEF);
      access(0, 2'd1, 1, 64'h6, 64'h0, rd, er);
      check("ld_h6_u", rd, 64'hCDEF);
      access(0, 2'd1, 0, 64'h6, 64'h0, rd, er);
      check("ld_h6_s", rd, 64'hFFFFFFFFFFFFCDEF);
      access(0, 2'd2, 1, 64'h4, 64'h0, rd, er);
      check("ld_w4_u", rd, 64'h89ABCDEF);
      access(0, 2'd3, 1, 64'h0, 64'h0, rd, er);
      check("ld_d0", rd, 64'h0123456789ABCDEF);

      // Sub-word store into the middle of the dword
      access(1, 2'd1, 0, 64'h2, 64'hFFFF_FFFF_FFFF_5AA5, rd, er);
      check("st_h2_err", er, 0);
      access(0, 2'd3, 0, 64'h0, 64'h0, rd, er);
      check("ld_d0_after_h", rd, 64'h01235AA589ABCDEF);

      // Errors: misalignment and range
      access(0, 2'd2, 0, 64'h2, 64'h0, rd, er);
      check("misalign_err", er, 1);
      check("misalign_rdata", rd, 0);
      access(1, 2'd2, 0, 64'h3C, 64'h11223344, rd, er);
      check("st_w3c_err", er, 0);
      access(1, 2'd3, 0, 64'h3C, 64'hDEADBEEFCAFEF00D, rd, er);
      check("st_d3c_err", er, 1);
      access(0, 2'd2, 1, 64'h3C, 64'h0, rd, er);
      check("ram_unchanged", rd, 64'h11223344);
      access(0, 2'd0, 1, 64'h3F, 64'h0, rd, er);
      check("ld_b3f_edge_err", er, 0);
      check("ld_b3f_edge", rd, 64'h44);
      access(0, 2'd3, 0, 64'h40, 64'h0, rd, er);
      check("range_err", er, 1);
      check("range_rdata", rd, 0);

      // LED block
      access(1, 2'd3, 0, 64'h1000, 64'hA5, rd, er);
      check("led_wr", led, 8'hA5);
      access(1, 2'd3, 0, 64'h1008, 64'h0F, rd, er);
      check("led_set", led, 8'hAF);
      access(1, 2'd3, 0, 64'h1010, 64'h81, rd, er);
      check("led_clr", led, 8'h2E);
      access(1, 2'd3, 0, 64'h1018, 64'hFF, rd, er);
      check("led_tgl", led, 8'hD1);
      access(0, 2'd3, 0, 64'h1000, 64'h0, rd, er);
      check("led_rd", rd, 64'hD1);
      access(1, 2'd0, 0, 64'h1000, 64'h00, rd, er);
      check("led_byte_err", er, 1);
      check("led_byte_noeff", led, 8'hD1);

      // Switch block
      swi = 8'h80;
      repeat (4) @(posedge clk);
      access(0, 2'd3, 0, 64'h2000, 64'h0, rd, er);
      check("sw_val_s", rd, 64'hFFFFFFFFFFFFFF80);
      access(0, 2'd3, 1, 64'h2000, 64'h0, rd, er);
      check("sw_val_u", rd, 64'h80);
      access(0, 2'd3, 0, 64'h2008, 64'h0, rd, er);
      check("sw_chg", rd, 64'h80);
      access(0, 2'd3, 0, 64'h2008, 64'h0, rd, er);
      check("sw_chg_cleared", rd, 64'h0);
      access(1, 2'd3, 0, 64'h2000, 64'hFF, rd, er);
      check("sw_store_err", er, 0);

      // Back-to-back: second request held valid through the BUSY cycle
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_unsigned = 1'b0;
      req_addr = 64'h0; req_wdata = '0;
      @(posedge clk); #1;
      req_addr = 64'h1000;
      check("b2b_busy_ready", req_ready, 0);
      @(posedge clk); #1;
      check("b2b_rsp1_valid", rsp_valid, 1);
      check("b2b_rsp1_data", rsp_rdata, 64'h01235AA589ABCDEF);
      check("b2b_ready_again", req_ready, 1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("b2b_accept2", req_ready, 0);
      check("b2b_rsp1_pulse", rsp_valid, 0);
      @(posedge clk); #1;
      check("b2b_rsp2_valid", rsp_valid, 1);
      check("b2b_rsp2_data", rsp_rdata, 64'hD1);

      access(0, 2'd3, 0, 64'h3000, 64'h0, rd, er);
      check("unmapped_err", er, 1);
      check("unmapped_rdata", rd, 0);

      // Reset during BUSY with a pending change flag
      swi = 8'h00;
      repeat (5) @(posedge clk);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd3; req_unsigned = 1'b0;
      req_addr = 64'h1000; req_wdata = 64'h77;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("inflight_led", led, 8'h77);
      rst = 1'b1;
      #1;
      check("midrst_led", led, 0);
      check("midrst_valid", rsp_valid, 0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("midrst_no_pulse", rsp_valid, 0);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_ready", req_ready, 1);
      check("post_rst_valid", rsp_valid, 0);
      access(0, 2'd3, 0, 64'h2008, 64'h0, rd, er);
      check("post_rst_chg", rd, 64'h0);
      access(0, 2'd3, 0, 64'h0, 64'h0, rd, er);
      check("post_rst_ram", rd, 64'h01235AA589ABCDEF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/data_memory_mmio.md
Name: data_memory_mmio

Overview:
- Parametrised successor to the single-cycle data memory of the monocycle processor.
- Byte-addressed big-endian RAM plus memory-mapped LED and switch I/O, decoded from the region bits ADDR[13:12].
- Adds sized and sign-extended accesses, alignment and range error reporting, a registered one-cycle read, LED set/clear/toggle registers, and synchronised switches with sticky change flags.
- Sits between the processor datapath (load/store unit) and board I/O.

Parameters:
- XLEN, 64, data and address width.
- DEPTH_BYTES, 64, RAM size in bytes (power of 2, minimum 8).
- N_LED, 8, LED output count (1..XLEN).
- N_SW, 8, switch input count (1..XLEN).
- SYNC_STAGES, 2, switch synchroniser depth (minimum 2).
- INIT_FILE, "", binary RAM image; skipped if empty.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  access request.
- req_ready  out  1  request accepted this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword.
- req_unsigned  in  1  zero-extend loads when 1, sign-extend when 0.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-justified.
- rsp_valid  out  1  response strobe.
- rsp_rdata  out  XLEN  load result.
- rsp_err  out  1  access fault.
- swi  in  N_SW  asynchronous switch inputs.
- led  out  N_LED  LED drive.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: led = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, req_ready = 0, synchroniser = 0, change flags = 0, state = IDLE. RAM contents are not reset.
- FSM IDLE / BUSY:
  - IDLE: req_ready = 1. A request fires when req_valid & req_ready; the FSM then goes to BUSY.
  - BUSY: req_ready = 0. On the next cycle rsp_valid = 1 for exactly one cycle, then the FSM returns to IDLE.
  - Throughput is one access per 2 cycles. Latency is 1 cycle from accept to response for both loads and stores.
- Region decode, ADDR[13:12]:
  - 00: RAM.
  - 01: LED block.
  - 10: switch block.
  - 11: unmapped; rsp_err = 1, no side effect, rsp_rdata = 0.
- Error (rsp_err = 1, rdata 0, no state change) on any of:
  - Misalignment: addr mod (1 << size) != 0.
  - RAM access with ADDR[11:0] + (1 << size) > DEPTH_BYTES.
  - Any I/O access with size != 3 or ADDR[2:0] != 0.
- RAM:
  - Big-endian: byte at addr is the most significant byte of the accessed unit.
  - Stores write the low (8 << size) bits of req_wdata at the accept edge.
  - Loads are sampled at the accept edge. A store followed by a load of the same address returns the new data.
- LED offsets (ADDR[4:3]):
  - 0: write, led = wdata[N_LED-1:0].
  - 1: set, led |= wdata.
  - 2: clear, led &= ~wdata.
  - 3: toggle, led ^= wdata.
  - Reads of any LED offset return led zero-extended.
- Switch offsets:
  - 0: read the synchronised value, zero-extended when req_unsigned = 1, else sign-extended from bit N_SW-1.
  - 1: read the sticky change flags, then clear them. A bit is set whenever the synchronised value differs from its previous cycle's value. A change in the same cycle as the read-clear keeps its bit set.
  - Stores to the switch block: rsp_err = 0, no effect.
- Width rules: load extension is from bit (8 << size) - 1. Dword loads ignore req_unsigned.
- Reset mid-operation: an in-flight BUSY response is discarded and rsp_valid stays 0. A store completed before reset remains in RAM.

Decomposition:
- Package dmem_pkg holds:
  - Region enum: REG_RAM, REG_LED, REG_SW, REG_NONE.
  - Size enum: SZ_B, SZ_H, SZ_W, SZ_D.
  - LED offset constants: LED_WR, LED_SET, LED_CLR, LED_TGL.
  - Switch offset constants: SW_VAL, SW_CHG.
  - FSM state typedef.
- Sub-module sw_sync (parameters N_SW, SYNC_STAGES) contains the synchroniser flop chain and the sticky change-flag logic with a read-clear input.

Test Plan:
- Store dword 0x0123456789ABCDEF at 0x0, then load byte at 0x0 signed -> 0x01. Load byte at 0x7 signed -> 0xFFFFFFFFFFFFFFEF. Load half at 0x6 unsigned -> 0xCDEF. Each rsp_valid arrives exactly 1 cycle after accept.
- Load word at 0x2 -> rsp_err = 1, rdata 0. Store dword at 0x3C with DEPTH_BYTES = 64 -> rsp_err = 1 and RAM unchanged.
- LED sequence: write 0xA5 to 0x1000, set 0x0F at 0x1008, clear 0x81 at 0x1010, toggle 0xFF at 0x1018 -> led = 0xA5, 0xAF, 0x2E, 0xD1. Loading 0x1000 returns 0xD1.
- swi = 0x80 held: after SYNC_STAGES + 1 cycles, signed load of 0x2000 -> 0xFFFFFFFFFFFFFF80 and unsigned -> 0x80. Load 0x2008 -> 0x80; an immediate reload -> 0x00.
- Back-to-back req_valid: req_ready is low in the BUSY cycle and the second request is accepted one cycle later. Access to 0x3000 -> rsp_err = 1.
- Assert rst while BUSY: rsp_valid never pulses, led = 0 and change flags = 0 immediately, and req_ready = 1 in the first cycle after release.
